// File: rtl/alu32_pkg.sv
// Shared op codes, FSM state encoding and defaults for the ALU32 logic-unit issue block.
package alu32_pkg;

   typedef enum logic [1:0] {
      LOGIC_AND = 2'b00,
      LOGIC_OR  = 2'b01,
      LOGIC_XOR = 2'b10,
      LOGIC_NOR = 2'b11
   } logic_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int DEFAULT_SETTLE_CYCLES = 1;

   // Enable vector is ordered {nor, xor, or, and}, so the bit index equals the op code.
   function automatic logic [3:0] op_onehot(logic_op_t op);
      return 4'b0001 << op;
   endfunction

endpackage

// File: rtl/alu32_logic_issue_if.sv
// Request/response handshakes plus the operand/enable/return bus to the logic-unit array.
interface alu32_logic_issue_if #(
   parameter int WIDTH = 32
);
   logic             ReqValid;
   logic             ReqReady;
   logic [1:0]       ReqOp;
   logic [WIDTH-1:0] ReqA;
   logic [WIDTH-1:0] ReqB;

   logic [WIDTH-1:0] UnitIn1;
   logic [WIDTH-1:0] UnitIn2;
   logic             EnAnd;
   logic             EnOr;
   logic             EnXor;
   logic             EnNor;
   logic [WIDTH-1:0] RetAnd;
   logic [WIDTH-1:0] RetOr;
   logic [WIDTH-1:0] RetXor;
   logic [WIDTH-1:0] RetNor;

   logic             RespValid;
   logic             RespReady;
   logic [WIDTH-1:0] Result;
   logic             Zero;

   // Environment side: requester, consumer and the logic units themselves.
   modport master (
      output ReqValid, ReqOp, ReqA, ReqB, RespReady,
      output RetAnd, RetOr, RetXor, RetNor,
      input  ReqReady, RespValid, Result, Zero,
      input  UnitIn1, UnitIn2, EnAnd, EnOr, EnXor, EnNor
   );

   modport slave (
      input  ReqValid, ReqOp, ReqA, ReqB, RespReady,
      input  RetAnd, RetOr, RetXor, RetNor,
      output ReqReady, RespValid, Result, Zero,
      output UnitIn1, UnitIn2, EnAnd, EnOr, EnXor, EnNor
   );

endinterface

// File: rtl/alu32_logic_issue.sv
// Sequential initiator: accepts one logic request, enables one unit for a fixed settle
// time, captures its result and zero flag, and returns them over the response handshake.
module alu32_logic_issue
   import alu32_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
   input logic                Clk,
   input logic                Reset,
   alu32_logic_issue_if.slave bus
);

   state_t           state;
   logic_op_t        op_q;
   logic [3:0]       cnt;
   logic [3:0]       en_next;
   logic [WIDTH-1:0] sel_ret;

   assign bus.ReqReady = (state == IDLE) && !Reset;

   always_comb begin
      en_next = op_onehot(logic_op_t'(bus.ReqOp));
   end

   // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      sel_ret = '0;
      unique case (op_q)
         LOGIC_AND: sel_ret = bus.RetAnd;
         LOGIC_OR:  sel_ret = bus.RetOr;
         LOGIC_XOR: sel_ret = bus.RetXor;
         LOGIC_NOR: sel_ret = bus.RetNor;
      endcase
   end

   // NOTE: state and registered outputs use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state         <= IDLE;
         op_q          <= LOGIC_AND;
         cnt           <= '0;
         bus.UnitIn1   <= '0;
         bus.UnitIn2   <= '0;
         {bus.EnNor, bus.EnXor, bus.EnOr, bus.EnAnd} <= '0;
         bus.RespValid <= 1'b0;
         bus.Result    <= '0;
         bus.Zero      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               // ReqReady is high whenever we are here out of reset.
               if (bus.ReqValid) begin
                  op_q        <= logic_op_t'(bus.ReqOp);
                  cnt         <= 4'(SETTLE_CYCLES);
                  bus.UnitIn1 <= bus.ReqA;
                  bus.UnitIn2 <= bus.ReqB;
                  {bus.EnNor, bus.EnXor, bus.EnOr, bus.EnAnd} <= en_next;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  bus.Result    <= sel_ret;
                  bus.Zero      <= (sel_ret == '0);
                  bus.UnitIn1   <= '0;
                  bus.UnitIn2   <= '0;
                  {bus.EnNor, bus.EnXor, bus.EnOr, bus.EnAnd} <= '0;
                  bus.RespValid <= 1'b1;
                  state         <= DONE;
               end
            end
            DONE: begin
               if (bus.RespReady) begin
                  bus.RespValid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu32_logic_issue.md
Name: alu32_logic_issue

Overview:
Sequential initiator for the ALU32 gate-level logic units (AND/OR/XOR/NOR, 32-bit, each with an active-high Enable input).
- Accepts one logic request over a valid/ready handshake.
- Drives the operands and exactly one unit Enable.
- Waits a fixed settle time, captures the selected unit's result plus a zero flag, and returns it over a second valid/ready handshake.
- Sits between the ALU32 opcode decode and the logic-unit array.

Parameters:
WIDTH, 32, operand/result width.
SETTLE_CYCLES, 1, clock edges the Enable is held before result capture; legal range 1..15.

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  synchronous, active-high reset.
ReqValid  input  1  request present.
ReqReady  output  1  block can accept a request.
ReqOp  input  2  00 AND, 01 OR, 10 XOR, 11 NOR.
ReqA  input  WIDTH  operand 1.
ReqB  input  WIDTH  operand 2.
UnitIn1  output  WIDTH  operand 1 to all logic units.
UnitIn2  output  WIDTH  operand 2 to all logic units.
EnAnd  output  1  Enable to AND unit.
EnOr  output  1  Enable to OR unit.
EnXor  output  1  Enable to XOR unit.
EnNor  output  1  Enable to NOR unit.
RetAnd  input  WIDTH  AND unit output.
RetOr  input  WIDTH  OR unit output.
RetXor  input  WIDTH  XOR unit output.
RetNor  input  WIDTH  NOR unit output.
RespValid  output  1  result available.
RespReady  input  1  consumer takes result.
Result  output  WIDTH  captured result.
Zero  output  1  Result == 0.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high: sampled on the Clk rising edge only.
- Reset values: state=IDLE, all En* 0, UnitIn1/UnitIn2 0, RespValid 0, Result 0, Zero 0, settle counter 0. ReqReady is 0 while Reset is high.
- FSM states: IDLE, BUSY, DONE.
- ReqReady = (state==IDLE) && !Reset. It is combinational from state only and never depends on ReqValid.
- IDLE, on ReqValid && ReqReady at an edge:
  - latch ReqA, ReqB, ReqOp;
  - load counter with SETTLE_CYCLES;
  - go to BUSY.
  - With ReqValid low, stay in IDLE.
- BUSY:
  - UnitIn1/UnitIn2 = latched operands, stable for the whole state.
  - Exactly one En* = 1, one-hot decoded from the latched op.
  - The counter decrements each edge.
  - At the edge where the counter equals 1: Result <= Ret* selected by the latched op (the other Ret* are ignored); Zero <= (selected Ret* == 0); go to DONE.
- DONE:
  - En* all 0; UnitIn1/UnitIn2 driven to 0.
  - RespValid = 1. Result and Zero are held stable until RespReady is sampled high, then go to IDLE.
- Latency: RespValid rises SETTLE_CYCLES edges after the request-acceptance edge. Minimum request spacing is SETTLE_CYCLES+2 cycles.
- RespValid is registered and never drops without RespReady. It is not asserted in the same cycle as ReqReady.
- At most one En* is high in any cycle. All En* are 0 outside BUSY.
- ReqReady is 0 in BUSY and DONE. A ReqValid arriving there is not accepted, has no effect, and is not lost to the requester, who must hold it.
- Reset asserted in BUSY or DONE aborts the operation at the next edge: all outputs take reset values and no response is produced.
- Result holds its last value in IDLE. It is only meaningful while RespValid=1.

Decomposition:
- alu32_pkg holds:
  - op codes (LOGIC_AND=2'b00, LOGIC_OR=2'b01, LOGIC_XOR=2'b10, LOGIC_NOR=2'b11);
  - FSM state encoding (IDLE, BUSY, DONE);
  - default SETTLE_CYCLES.
- No sub-module. The one-hot enable decode and the result select are small combinational blocks inside this module.
- The bench instantiates the real G_Xor32 and its sibling units as responders.

Test Plan:
1. XOR, SETTLE_CYCLES=1: A=0xFFFF0000, B=0x0F0F0F0F, RespReady=1 → EnXor high for exactly 1 cycle, other En* 0; RespValid 1 edge after acceptance; Result=0xF0F00F0F; Zero=0.
2. Zero flag: XOR with A=B=0x12345678 → Result=0x00000000, Zero=1. Then AND with A=0x80000001, B=0x80000000 → Result=0x80000000, Zero=0.
3. Backpressure: OR with A=0x00FF00FF, B=0xFF000000, RespReady held 0 for 5 cycles → RespValid stays 1; Result=0xFFFF00FF stable; ReqReady=0 throughout; a second ReqValid is not accepted until one cycle after RespReady is taken.
4. SETTLE_CYCLES=4, NOR with A=0, B=0 → EnNor high for exactly 4 cycles with UnitIn1/UnitIn2 stable; Result=0xFFFFFFFF captured at the 4th edge.
5. Reset mid-operation: assert Reset in the 2nd BUSY cycle (SETTLE_CYCLES=4) → next edge: all En*=0, RespValid=0, Result=0. ReqReady=1 one cycle after Reset deasserts; no stale response appears.
6. Back-to-back ops: four ops, one per op code, RespReady=1, random operands → each Result matches a bit-accurate reference model; En* one-hot checked every cycle; spacing exactly SETTLE_CYCLES+2 cycles.
